rv32_writeback: RTL and testbench

- Writeback stage driving the write port of the RV32I integer register file: `wr_en`, `rd_address`, `rd_data`.
- Merges two result sources:
  - single-cycle ALU results;
  - in-order load responses from data memory.
- Tracks outstanding loads in a small queue and performs byte/halfword extraction with sign or zero extension.
- Registers the selected result, so the register file sees one clean write per cycle.

---
 rtl/rv32_writeback.sv | 237 +++++++++++++++++++++++
 tb/tb_rv32_writeback.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_writeback.sv
// rtl/rv32_writeback.sv - RV32I writeback stage merging ALU results and in-order load responses
//
// Purpose:
//   Drives the single write port of the integer register file. Two sources
//   compete for it: single-cycle ALU results and load responses coming back
//   from data memory in issue order. Outstanding loads are remembered in a
//   small FIFO of {rd, funct3, addr_lo}. When a response arrives, the FIFO
//   head is used to pick the byte/half/word and to sign- or zero-extend it.
//   The chosen result is registered, so the register file sees at most one
//   clean write per cycle, one cycle after acceptance.
//
// Parameters:
//   LD_DEPTH          outstanding load capacity (power of two, >= 2)
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   alu_valid/ready   ALU result handshake; ALU holds rd/data until ready
//   alu_rd, alu_data  ALU destination register and result
//   ld_issue_valid    load issued to memory (pushes one queue entry)
//   ld_issue_ready    queue not full
//   ld_issue_rd       load destination register
//   ld_issue_funct3   RV32I load funct3
//   ld_issue_addr_lo  byte offset (address bits [1:0])
//   mem_rsp_valid     one aligned word per issued load, in order
//   mem_rsp_data      aligned 32-bit memory word
//   wr_en             register file write enable
//   rd_address        register file write address
//   rd_data           register file write data
//   err_unexpected    sticky: response seen while no load was outstanding
//
// Optional feature (macro WB_SCOREBOARD_EN):
//   rs1_address, rs2_address  source registers of the instruction in decode
//   rs1_busy, rs2_busy        a queued load still targets that register

module rv32_writeback #(
  parameter int LD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_issue_valid,
  output logic        ld_issue_ready,
  input  logic [4:0]  ld_issue_rd,
  input  logic [2:0]  ld_issue_funct3,
  input  logic [1:0]  ld_issue_addr_lo,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        wr_en,
  output logic [4:0]  rd_address,
  output logic [31:0] rd_data,
`ifdef WB_SCOREBOARD_EN
  input  logic [4:0]  rs1_address,
  input  logic [4:0]  rs2_address,
  output logic        rs1_busy,
  output logic        rs2_busy,
`endif
  output logic        err_unexpected
);

  localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LD_DEPTH);

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // ------------------------------------------------------------------
  // Load queue state
  // ------------------------------------------------------------------
  logic [4:0]    q_rd [LD_DEPTH];
  logic [2:0]    q_f3 [LD_DEPTH];
  logic [1:0]    q_lo [LD_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic q_full;
  logic q_empty;
  logic push;
  logic pop;
  logic stray_rsp;

  assign q_full  = (count == DEPTH_C);
  assign q_empty = (count == '0);

  // No bypass: a full queue refuses an issue even if a pop happens now,
  // which keeps ld_issue_ready independent of mem_rsp_valid.
  assign ld_issue_ready = !q_full;
  assign push           = ld_issue_valid && !q_full;
  assign pop            = mem_rsp_valid && !q_empty;
  assign stray_rsp      = mem_rsp_valid && q_empty;

  // A load response owns the write port; the ALU waits one cycle.
  assign alu_ready = !pop;

  // Entry storage carries no reset: validity is defined by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr] <= ld_issue_rd;
      q_f3[wr_ptr] <= ld_issue_funct3;
      q_lo[wr_ptr] <= ld_issue_addr_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // Load data extraction from the head entry
  // ------------------------------------------------------------------
  logic [4:0]  head_rd;
  logic [2:0]  head_f3;
  logic [1:0]  head_lo;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_value;

  assign head_rd = q_rd[rd_ptr];
  assign head_f3 = q_f3[rd_ptr];
  assign head_lo = q_lo[rd_ptr];

  always_comb begin
    byte_sel = mem_rsp_data[7:0];
    case (head_lo)
      2'd0: byte_sel = mem_rsp_data[7:0];
      2'd1: byte_sel = mem_rsp_data[15:8];
      2'd2: byte_sel = mem_rsp_data[23:16];
      2'd3: byte_sel = mem_rsp_data[31:24];
      default: byte_sel = mem_rsp_data[7:0];
    endcase
  end

  // Halfword selection uses only addr_lo[1]; a misaligned bit 0 is ignored.
  assign half_sel = head_lo[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];

  always_comb begin
    ld_value = mem_rsp_data;
    case (head_f3)
      F3_LB:   ld_value = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  ld_value = {24'd0, byte_sel};
      F3_LH:   ld_value = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  ld_value = {16'd0, half_sel};
      default: ld_value = mem_rsp_data;  // LW and unused encodings
    endcase
  end

  // ------------------------------------------------------------------
  // Output register and sticky error
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en          <= 1'b0;
      rd_address     <= 5'd0;
      rd_data        <= 32'd0;
      err_unexpected <= 1'b0;
    end else begin
      if (pop) begin
        rd_address <= head_rd;
        rd_data    <= ld_value;
        wr_en      <= (head_rd != 5'd0);
      end else if (alu_valid) begin
        rd_address <= alu_rd;
        rd_data    <= alu_data;
        wr_en      <= (alu_rd != 5'd0);
      end else begin
        // Address and data hold; only the enable drops.
        wr_en <= 1'b0;
      end
      if (stray_rsp) begin
        err_unexpected <= 1'b1;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  // ------------------------------------------------------------------
  // Busy scoreboard: per-entry valid bits so every queued rd can be
  // compared against the decode-stage sources in parallel.
  // ------------------------------------------------------------------
  logic [LD_DEPTH-1:0] q_vld;

  // push and pop can never address the same slot in one cycle: equal
  // pointers mean empty (no pop) or full (no push).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_vld <= '0;
    end else begin
      if (push) begin
        q_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        q_vld[rd_ptr] <= 1'b0;
      end
    end
  end

  // Uses registered queue state only, so an entry popped this cycle still
  // reports busy now and clears next cycle, when its write is forwardable.
  always_comb begin
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    for (int i = 0; i < LD_DEPTH; i++) begin
      if (q_vld[i] && (q_rd[i] == rs1_address) && (rs1_address != 5'd0)) begin
        rs1_busy = 1'b1;
      end
      if (q_vld[i] && (q_rd[i] == rs2_address) && (rs2_address != 5'd0)) begin
        rs2_busy = 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rv32_writeback.sv
// tb/tb_rv32_writeback.sv - scoreboard testbench for rv32_writeback
module tb_rv32_writeback;

  localparam int LD_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_issue_valid = 1'b0;
  logic        ld_issue_ready;
  logic [4:0]  ld_issue_rd = '0;
  logic [2:0]  ld_issue_funct3 = '0;
  logic [1:0]  ld_issue_addr_lo = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        wr_en;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
  logic        err_unexpected;
  logic [4:0]  rs1_address = '0;
  logic [4:0]  rs2_address = '0;
  logic        rs1_busy;
  logic        rs2_busy;

  always #5 clk = ~clk;

  rv32_writeback #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_ready(ld_issue_ready),
    .ld_issue_rd(ld_issue_rd), .ld_issue_funct3(ld_issue_funct3),
    .ld_issue_addr_lo(ld_issue_addr_lo),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .wr_en(wr_en), .rd_address(rd_address), .rd_data(rd_data),
`ifdef WB_SCOREBOARD_EN
    .rs1_address(rs1_address), .rs2_address(rs2_address),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`endif
    .err_unexpected(err_unexpected)
  );

`ifndef WB_SCOREBOARD_EN
  assign rs1_busy = 1'b0;
  assign rs2_busy = 1'b0;
`endif

  typedef struct {logic [4:0] rd; logic [2:0] f3; logic [1:0] lo;} ld_t;
  typedef struct {logic we; logic [4:0] rd; logic [31:0] data; logic err;} exp_t;

  ld_t   mq[$];
  exp_t  eq[$];
  logic [4:0]  h_rd = '0;
  logic [31:0] h_data = '0;
  logic        m_err = 1'b0;
  int total = 0;
  int bad = 0;
  bit alu_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load extraction, straight from the funct3 rules.
  function automatic logic [31:0] extract(input ld_t e, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * e.lo)) & 32'hFF;
    h = (w >> (16 * (e.lo / 2))) & 32'hFFFF;
    case (e.f3)
      3'b000:  return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'b100:  return b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic bit busy_of(input logic [4:0] rs);
    if (rs == 0) return 0;
    foreach (mq[i]) if (mq[i].rd == rs) return 1;
    return 0;
  endfunction

  // Monitor: one expectation per driven cycle, compared after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (eq.size() > 0) begin
        e = eq.pop_front();
        check("wr_en", 32'(wr_en), 32'(e.we));
        check("rd_address", 32'(rd_address), 32'(e.rd));
        check("rd_data", rd_data, e.data);
        check("err_unexpected", 32'(err_unexpected), 32'(e.err));
      end
    end
  end

  task automatic do_reset(input int cycles);
    exp_t e;
    e.we = 0; e.rd = 0; e.data = 0; e.err = 0;
    repeat (cycles) begin
      @(negedge clk);
      rst = 1'b1;
      alu_valid = 0; ld_issue_valid = 0; mem_rsp_valid = 0;
      mq.delete();
      h_rd = 0; h_data = 0; m_err = 0;
      eq.push_back(e);
    end
  endtask

  task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] adat,
                      input bit iv, input logic [4:0] ird, input logic [2:0] if3,
                      input logic [1:0] ilo, input bit rv, input logic [31:0] rdat);
    exp_t e;
    ld_t  l;
    bit   pop_m, full_m, empty_m;
    @(negedge clk);
    rst = 1'b0;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_issue_valid = iv; ld_issue_rd = ird; ld_issue_funct3 = if3; ld_issue_addr_lo = ilo;
    mem_rsp_valid = rv; mem_rsp_data = rdat;
    #1;
    empty_m = (mq.size() == 0);
    full_m  = (mq.size() >= LD_DEPTH);
    pop_m   = rv && !empty_m;
    check("alu_ready", 32'(alu_ready), 32'(!pop_m));
    check("ld_issue_ready", 32'(ld_issue_ready), 32'(!full_m));
`ifdef WB_SCOREBOARD_EN
    check("rs1_busy", 32'(rs1_busy), 32'(busy_of(rs1_address)));
    check("rs2_busy", 32'(rs2_busy), 32'(busy_of(rs2_address)));
`endif
    e.we = 0;
    if (pop_m) begin
      l = mq.pop_front();
      h_rd = l.rd; h_data = extract(l, rdat); e.we = (l.rd != 0);
    end else if (av) begin
      h_rd = ard; h_data = adat; e.we = (ard != 0);
    end
    if (rv && empty_m) m_err = 1;
    if (iv && !full_m) begin
      l.rd = ird; l.f3 = if3; l.lo = ilo;
      mq.push_back(l);
    end
    alu_acc = av && !pop_m;
    e.rd = h_rd; e.data = h_data; e.err = m_err;
    eq.push_back(e);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic post(input string name, input logic [31:0] act_sel, input logic [31:0] exp);
    @(posedge clk);
    #3;
    case (act_sel)
      0: check(name, 32'(wr_en), exp);
      1: check(name, 32'(rd_address), exp);
      2: check(name, rd_data, exp);
      default: check(name, 32'(err_unexpected), exp);
    endcase
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit av; logic [4:0] ard; logic [31:0] adat;
    do_reset(2);
    check("reset wr_en", 32'(wr_en), 0);
    check("reset rd_data", rd_data, 0);

    // ALU write, then idle
    step(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
    post("alu x5 data", 2, 32'hDEAD_BEEF);
    idle();
    post("idle wr_en", 0, 0);

    // Sub-word loads
    step(0, 0, 0, 1, 7, 3'b000, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_FF12);
    post("lb", 2, 32'hFFFF_FF80);
    step(0, 0, 0, 1, 7, 3'b100, 3, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_FF12);
    post("lbu", 2, 32'h0000_0080);
    step(0, 0, 0, 1, 7, 3'b001, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_FF12);
    post("lh", 2, 32'hFFFF_80FF);
    step(0, 0, 0, 1, 7, 3'b101, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h80FF_FF12);
    post("lhu", 2, 32'h0000_FF12);

    // Collision: load first, ALU next cycle
    step(0, 0, 0, 1, 4, 3'b010, 0, 0, 0);
    step(1, 3, 32'h11, 0, 0, 0, 0, 1, 32'hCAFE_0001);
    check("collision alu held", 32'(alu_acc), 0);
    post("collision load rd", 1, 4);
    step(1, 3, 32'h11, 0, 0, 0, 0, 0, 0);
    post("collision alu data", 2, 32'h11);

    // Fill, refused 5th issue during a response, then wrap
`ifdef WB_SCOREBOARD_EN
    rs1_address = 9; rs2_address = 0;
`endif
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 5'(9 + k), 3'b010, 0, 0, 0);
    step(0, 0, 0, 1, 20, 3'b010, 0, 1, 32'h1000_0000);
    step(0, 0, 0, 1, 20, 3'b010, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0, 1, 5'(21 + k), 3'b010, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1, 32'h2000_0000 + 32'(k));
    end
    while (mq.size() > 0) step(0, 0, 0, 0, 0, 0, 0, 1, $urandom);
    // Two loads to x9: busy until the second response
    step(0, 0, 0, 1, 9, 3'b010, 0, 0, 0);
    step(0, 0, 0, 1, 9, 3'b010, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h99);
    idle();
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h98);
    idle();

    // x0 writes suppressed
    step(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0);
    post("alu x0 wr_en", 0, 0);
    step(0, 0, 0, 1, 0, 3'b010, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555);
    post("lw x0 wr_en", 0, 0);

    // Stray response with ALU alongside
    step(1, 6, 32'h66, 0, 0, 0, 0, 1, 32'h7777);
    post("stray err", 3, 1);
    idle();
    idle();

    // Randomized traffic with one mid-run reset
    av = 0; ard = 0; adat = 0;
    for (int n = 0; n < 600; n++) begin
      bit iv, rv;
      if (n == 300) begin
        do_reset(1);
        av = 0;
        step(0, 0, 0, 0, 0, 0, 0, 1, 32'h1);
      end
      if (!av || alu_acc) begin
        av = ($urandom % 2) == 1; ard = 5'($urandom); adat = $urandom;
      end
      iv = ($urandom % 3) != 0;
      rv = (mq.size() > 0) ? (($urandom % 2) == 1) : (($urandom % 64) == 0);
`ifdef WB_SCOREBOARD_EN
      rs1_address = 5'($urandom % 4); rs2_address = 5'($urandom % 4);
`endif
      step(av, ard, adat, iv, 5'($urandom % 4), 3'($urandom), 2'($urandom), rv, $urandom);
    end
    while (mq.size() > 0) step(0, 0, 0, 0, 0, 0, 0, 1, $urandom);
    idle();
    repeat (3) @(posedge clk);
    #3;
    check("scoreboard drained", 32'(eq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
